// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM block: register map and ctrl bit layout.
package pwm_multi_pkg;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_DUTY   = 2'd1;
    localparam logic [1:0] REG_PHASE  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_INV = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed period/duty, phase, ctrl, tick-driven counter and registered output.
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_period,
    input  logic             wr_duty,
    input  logic             wr_phase,
    input  logic             wr_ctrl,
    input  logic [WIDTH-1:0] wdata,
    output logic             out,
    output logic             period_end
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] ds_q, ds_d;
    logic [WIDTH-1:0] ph_q, ph_d;
    logic             en_q, en_d;
    logic             inv_q, inv_d;
    logic             out_q, out_d;
    logic             pe_q, pe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            p_q   <= '0;
            d_q   <= '0;
            ps_q  <= '0;
            ds_q  <= '0;
            ph_q  <= '0;
            en_q  <= 1'b0;
            inv_q <= 1'b0;
            out_q <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
            d_q   <= d_d;
            ps_q  <= ps_d;
            ds_q  <= ds_d;
            ph_q  <= ph_d;
            en_q  <= en_d;
            inv_q <= inv_d;
            out_q <= out_d;
            pe_q  <= pe_d;
        end
    end

    // Boundaries sample the shadow flops, so a same-cycle write lands one period later.
    always_comb begin
        cnt_d = cnt_q;
        p_d   = p_q;
        d_d   = d_q;
        ps_d  = ps_q;
        ds_d  = ds_q;
        ph_d  = ph_q;
        en_d  = en_q;
        inv_d = inv_q;
        out_d = inv_q;
        pe_d  = 1'b0;

        if (wr_period) ps_d = wdata;
        if (wr_duty)   ds_d = wdata;
        if (wr_phase)  ph_d = wdata;
        if (wr_ctrl) begin
            en_d  = wdata[CTRL_EN];
            inv_d = wdata[CTRL_INV];
        end

        if (!en_q) begin
            cnt_d = ph_q;
            p_d   = ps_q;
            d_d   = ds_q;
        end else begin
            out_d = (cnt_q < d_q) ^ inv_q;
            if (tick) begin
                if (cnt_q >= p_q) begin
                    cnt_d = '0;
                    p_d   = ps_q;
                    d_d   = ds_q;
                    pe_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign out        = out_q;
    assign period_end = pe_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: shared prescaler, register write decode and per-channel instances.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PRESC_W-1:0]                            presc,
    input  logic                                          cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                    cfg_addr,
    input  logic [WIDTH-1:0]                              cfg_wdata,
    output logic [CHANNELS-1:0]                           out,
    output logic [CHANNELS-1:0]                           period_end
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
    logic                tick_c;
    logic [CHANNELS-1:0] wr_period_c, wr_duty_c, wr_phase_c, wr_ctrl_c;

    always_ff @(posedge clk) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
    end

    // Down-counter; presc is only sampled on reload so a change waits for the next tick.
    always_comb begin
        tick_c = (pcnt_q == '0);
        pcnt_d = tick_c ? presc : pcnt_q - PRESC_W'(1);
    end

    // Out-of-range channel indices match no instance and are dropped.
    always_comb begin
        wr_period_c = '0;
        wr_duty_c   = '0;
        wr_phase_c  = '0;
        wr_ctrl_c   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                case (cfg_addr)
                    REG_PERIOD: wr_period_c[i] = 1'b1;
                    REG_DUTY:   wr_duty_c[i]   = 1'b1;
                    REG_PHASE:  wr_phase_c[i]  = 1'b1;
                    REG_CTRL:   wr_ctrl_c[i]   = 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_c),
            .wr_period  (wr_period_c[g]),
            .wr_duty    (wr_duty_c[g]),
            .wr_phase   (wr_phase_c[g]),
            .wr_ctrl    (wr_ctrl_c[g]),
            .wdata      (cfg_wdata),
            .out        (out[g]),
            .period_end (period_end[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with hand-derived waveforms and cycle positions.
module tb_pwm_multi;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESC_W  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [PRESC_W-1:0]  presc;
    logic                cfg_we;
    logic [1:0]          cfg_ch;
    logic [1:0]          cfg_addr;
    logic [WIDTH-1:0]    cfg_wdata;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] period_end;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    pwm_multi #(
        .CHANNELS(CHANNELS),
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .presc      (presc),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .out        (out),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_addr  = 2'(addr);
        cfg_wdata = 8'(data);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic wait_pe(input int ch);
        for (int i = 0; i < 400; i++) begin
            step();
            if (period_end[ch]) return;
        end
        check("pe_timeout", 32'd0, 32'd1);
    endtask

    // Reprogram ch3 while disabled, enable, then count high out/period_end cycles over 20 clocks.
    task automatic run_case(input string tag, input int p, input int d, input int inv,
                            input int exp_ones, input int exp_pe);
        int ones;
        int pes;
        wr(3, 3, 0);
        wr(3, 0, p);
        wr(3, 1, d);
        wr(3, 3, 1 | (inv << 1));
        for (int i = 0; i < 3; i++) step();
        ones = 0;
        pes  = 0;
        for (int i = 0; i < 20; i++) begin
            ones += int'(out[3]);
            pes  += int'(period_end[3]);
            step();
        end
        check({tag, "_out"}, 32'(ones), 32'(exp_ones));
        check({tag, "_pe"}, 32'(pes), 32'(exp_pe));
    endtask

    initial begin
        logic [9:0] rec_o;
        logic [9:0] rec_p;
        int ones;
        int pes;
        int r1, f1, r1b, r2;
        logic prev1, prev2;

        rst = 1'b1; presc = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_out", 32'(out), 32'd0);
        check("rst_pe", 32'(period_end), 32'd0);

        ones = 0; pes = 0;
        for (int i = 0; i < 50; i++) begin
            if (out != '0) ones++;
            if (period_end != '0) pes++;
            step();
        end
        check("idle_out", 32'(ones), 32'd0);
        check("idle_pe", 32'(pes), 32'd0);

        // Basic 5-clock waveform on ch0.
        wr(0, 0, 4);
        wr(0, 1, 2);
        wr(0, 3, 1);
        wait_pe(0);
        for (int i = 0; i < 10; i++) begin
            step();
            rec_o[i] = out[0];
            rec_p[i] = period_end[0];
        end
        check("basic_wave", 32'(rec_o), 32'(10'b0001100011));
        check("basic_pe", 32'(rec_p), 32'(10'b1000010000));

        // Duty write mid-period: current period keeps 2 highs, next gets 4.
        wait_pe(0);
        step();
        rec_o[0] = out[0];
        wr(0, 1, 4);
        rec_o[1] = out[0];
        for (int i = 2; i < 10; i++) begin
            step();
            rec_o[i] = out[0];
        end
        check("midwrite_wave", 32'(rec_o), 32'(10'b0111100011));

        // Duty write on the wrap cycle: takes one extra period to apply.
        wait_pe(0);
        for (int i = 0; i < 4; i++) step();
        wr(0, 1, 2);
        for (int i = 0; i < 10; i++) begin
            step();
            rec_o[i] = out[0];
        end
        check("wrapwrite_wave", 32'(rec_o), 32'(10'b0001101111));

        run_case("d0", 4, 0, 0, 0, 4);
        run_case("d200", 4, 200, 0, 20, 4);
        run_case("inv_d0", 4, 0, 1, 20, 4);
        run_case("p0", 0, 1, 0, 20, 20);

        // Disable ch0 at cnt=2 after setting PH=3, then re-enable.
        wr(0, 2, 3);
        wait_pe(0);
        step();
        step();
        wr(0, 3, 0);
        ones = 0; pes = 0;
        for (int i = 0; i < 10; i++) begin
            ones += int'(out[0]);
            pes  += int'(period_end[0]);
            step();
        end
        check("dis_out", 32'(ones), 32'd0);
        check("dis_pe", 32'(pes), 32'd0);
        wr(0, 3, 1);
        step();
        check("reen_pe_early", 32'(period_end[0]), 32'd0);
        step();
        check("reen_pe_at_ph", 32'(period_end[0]), 32'd1);
        step();
        check("reen_out", 32'(out[0]), 32'd1);

        // Reset mid-operation, then prescaled phase test with presc=9.
        check("pre_rst_out3", 32'(out[3]), 32'd1);
        presc = 16'd9;
        rst = 1'b1;
        step();
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_pe", 32'(period_end), 32'd0);
        step();
        rst = 1'b0;
        cyc = 0;
        wr(1, 0, 9);
        wr(1, 1, 5);
        wr(1, 2, 5);
        wr(2, 0, 9);
        wr(2, 1, 5);
        wr(2, 2, 0);
        check("post_rst_out", 32'(out), 32'd0);
        wr(1, 3, 1);
        wr(2, 3, 1);
        while (cyc < 100) step();

        r1 = -1; f1 = -1; r1b = -1; r2 = -1;
        prev1 = out[1];
        prev2 = out[2];
        for (int i = 0; i < 300; i++) begin
            step();
            if (out[1] && !prev1) begin
                if (r1 < 0) r1 = cyc;
                else if (r1b < 0) r1b = cyc;
            end
            if (!out[1] && prev1 && r1 >= 0 && f1 < 0) f1 = cyc;
            if (out[2] && !prev2 && r1 >= 0 && r2 < 0) r2 = cyc;
            prev1 = out[1];
            prev2 = out[2];
        end
        check("presc_period", 32'(r1b - r1), 32'd100);
        check("presc_high", 32'(f1 - r1), 32'd50);
        check("presc_lead", 32'(r2 - r1), 32'd50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator with a programmable period, duty, start phase and polarity per channel.
- A shared clock prescaler drives all channels.
- Period and duty writes go to shadow registers and take effect only at the channel's period boundary, so outputs never glitch.
- Drives LEDs, servos and motor drivers from the 50 MHz board clock, configured from a simple register-write port.

Parameters:
- CHANNELS, 4, number of independent PWM outputs (1..16).
- WIDTH, 8, bit width of the period, duty, phase and counter registers.
- PRESC_W, 16, bit width of the shared prescaler.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- presc  in  PRESC_W  prescaler reload value; a tick occurs every presc+1 clocks.
- cfg_we  in  1  register write strobe, one write per cycle.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel; writes with cfg_ch >= CHANNELS are ignored.
- cfg_addr  in  2  register select: 0 = period shadow, 1 = duty shadow, 2 = phase, 3 = ctrl (bit0 en, bit1 inv).
- cfg_wdata  in  WIDTH  write data.
- out  out  CHANNELS  PWM outputs, registered.
- period_end  out  CHANNELS  one-cycle pulse per channel when its counter wraps.

Behaviour:
- Reset (clk edge with rst=1) clears:
  - the prescaler counter;
  - every channel's cnt, P, D, Ps, Ds, PH, en and inv;
  - out=0 and period_end=0.
- After reset, outputs stay 0 until the channel is configured and enabled.
- Prescaler:
  - pcnt counts down.
  - tick=1 in the cycle where pcnt==0; pcnt then reloads presc.
  - presc=0 gives tick every cycle.
  - A change to presc takes effect at the next reload.
- Config writes land one cycle after the cfg_we cycle.
  - Period and duty writes go to Ps and Ds only.
  - Phase and ctrl writes are immediate.
- While en=0:
  - cnt is loaded with PH every cycle;
  - P<=Ps and D<=Ds every cycle;
  - out<=inv;
  - period_end<=0.
- While en=1, on each tick:
  - if cnt >= P: cnt<=0, P<=Ps, D<=Ds, and period_end pulses for 1 cycle;
  - otherwise cnt<=cnt+1.
- Without a tick, cnt, P and D hold.
- Output: out <= en ? ((cnt < D) ^ inv) : inv, registered one cycle behind cnt.
- Waveform: period = (P+1) ticks; active time = min(D, P+1) ticks.
- Boundary cases:
  - D=0 gives constant inactive level (out=inv).
  - D >= P+1 gives constant active level.
  - P=0 gives a counter fixed at 0: wrap on every tick, 1-tick period.
  - PH > P: the counter wraps to 0 on the first tick after enable.
  - A write to Ps/Ds in the same cycle as a boundary: the boundary loads the pre-write shadow value; the new value applies at the following boundary.
  - A ctrl write clearing en mid-period: next cycle out=inv, cnt=PH, with no partial pulse kept.
  - Re-enable restarts from PH with the current Ps/Ds.
  - A ctrl write toggling inv while enabled inverts out from the following cycle.
  - rst mid-operation overrides everything in the same cycle.
- Arithmetic: all comparisons are unsigned WIDTH-bit. cnt never exceeds max(P,PH), so there is no overflow.

Decomposition:
- Package pwm_multi_pkg holds:
  - register address constants REG_PERIOD=0, REG_DUTY=1, REG_PHASE=2, REG_CTRL=3;
  - ctrl bit indices CTRL_EN=0, CTRL_INV=1.
- Sub-module pwm_channel (parameter WIDTH) holds one channel's registers, counter, compare and output flop. It is instantiated CHANNELS times via generate.
- The prescaler and write decode stay in the top level.

Test Plan:
- Reset then idle: after rst high for 2 cycles, all out=0 and period_end=0 for 50 cycles with en=0.
- Basic waveform: presc=0; ch0 P=4, D=2, en=1. Required: out[0] repeats 1,1,0,0,0 (5-clock period), and period_end[0] pulses once every 5 clocks.
- Prescaler and phase: presc=9; ch1 P=9, D=5, PH=5; ch2 same with PH=0; enable both in one cycle. Required: both have a 100-clock period at 50% duty, with ch1 leading ch2 by 50 clocks.
- Glitch-free update: ch0 running P=4, D=2; write D=4 mid-period. Required: the current period keeps 2 high clocks, and the next period starts with 4 high clocks. Repeat the write on the exact wrap cycle: the change is delayed one more period.
- Extremes and polarity:
  - D=0 gives out=0 constantly.
  - D=200 with P=4 gives out=1 constantly.
  - inv=1 with D=0 gives out=1 constantly.
  - P=0, D=1 gives out=1 and period_end high on every tick.
- Disable and reset mid-period: clear en at cnt=2, then the next cycle out=inv with no pulse. Re-enable, and the counter restarts at PH. Assert rst mid-period: all state clears and out=0 the next cycle.
